// File: rtl/si_tag_start_stop.sv
// Start-stop interval stage: pairs START/STOP tags, saturates the difference to
// DIFF_WIDTH bits and streams the intervals out of a FWFT FIFO over AXI4-Stream.
module si_tag_start_stop #(
    parameter int DIFF_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_tag,
    input  logic [63:0]           tagtime,
    input  logic [4:0]            channel,
    input  logic                  rising_edge,
    input  logic                  enable,
    input  logic [4:0]            cfg_start_channel,
    input  logic                  cfg_start_rising,
    input  logic [4:0]            cfg_stop_channel,
    input  logic                  cfg_stop_rising,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DIFF_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tuser,
    output logic                  armed,
    output logic [15:0]           dropped_count
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, ARMED} state_e;

    state_e      state_q, state_d;
    logic [63:0] start_q, start_d;
    logic        is_start, is_stop, emit, relatch;

    assign is_start = valid_tag & enable & (channel == cfg_start_channel) & (rising_edge == cfg_start_rising);
    assign is_stop  = valid_tag & enable & (channel == cfg_stop_channel)  & (rising_edge == cfg_stop_rising);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (is_start) state_d = ARMED;
                ARMED:   if (is_stop && !is_start) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // A tag matching both START and STOP closes the current interval and opens the next.
    always_comb begin
        emit    = (state_q == ARMED) & is_stop;
        relatch = is_start;
        start_d = relatch ? tagtime : start_q;
    end

    assign armed = (state_q == ARMED);

    // Difference stage; a wrap (stop before start) lands in the upper bits and saturates.
    logic [63:0]           diff;
    logic                  sat;
    logic                  wr_vld_q;
    logic [DIFF_WIDTH-1:0] wr_data_q;
    logic                  wr_user_q;

    assign diff = tagtime - start_q;
    assign sat  = |diff[63:DIFF_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld_q  <= 1'b0;
            wr_data_q <= '0;
            wr_user_q <= 1'b0;
        end else begin
            wr_vld_q <= emit;
            if (emit) begin
                wr_data_q <= sat ? '1 : diff[DIFF_WIDTH-1:0];
                wr_user_q <= sat;
            end
        end
    end

    logic [DIFF_WIDTH:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       rd_ptr_q, wr_ptr_q;
    logic [AW:0]         count_q, count_d;
    logic [15:0]         dropped_q;
    logic                full, push_ok, pop;

    // Full looks only at the registered count, so a same-cycle pop never rescues a write.
    assign full    = (count_q == FULL_CNT);
    assign push_ok = wr_vld_q & ~full;
    assign pop     = m_axis_tvalid & m_axis_tready;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {wr_user_q, wr_data_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr_vld_q && full && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
        end
    end

    assign m_axis_tvalid = (count_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q][DIFF_WIDTH-1:0] : '0;
    assign m_axis_tuser  = m_axis_tvalid ? mem_q[rd_ptr_q][DIFF_WIDTH]     : 1'b0;
    assign dropped_count = dropped_q;

endmodule

// File: tb/tb_si_tag_start_stop.sv
// Directed bench: expected intervals are queued at stimulus time and popped by a
// monitor on every accepted AXI beat; control/status outputs are checked inline.
module tb_si_tag_start_stop;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_tag = 1'b0;
    logic [63:0] tagtime = '0;
    logic [4:0]  channel = '0;
    logic        rising_edge = 1'b0;
    logic        enable = 1'b1;
    logic [4:0]  cfg_start_channel = 5'd1;
    logic        cfg_start_rising = 1'b1;
    logic [4:0]  cfg_stop_channel = 5'd2;
    logic        cfg_stop_rising = 1'b1;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tuser;
    logic        armed;
    logic [15:0] dropped_count;

    int tests = 0;
    int fails = 0;
    logic [32:0] exp_q [$];

    si_tag_start_stop #(.DIFF_WIDTH(32), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .valid_tag(valid_tag), .tagtime(tagtime),
        .channel(channel), .rising_edge(rising_edge), .enable(enable),
        .cfg_start_channel(cfg_start_channel), .cfg_start_rising(cfg_start_rising),
        .cfg_stop_channel(cfg_stop_channel), .cfg_stop_rising(cfg_stop_rising),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .armed(armed), .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; presents one tag for exactly one cycle.
    task automatic send(input logic [63:0] t, input logic [4:0] ch, input logic r);
        valid_tag = 1'b1; tagtime = t; channel = ch; rising_edge = r;
        @(posedge clk); #1;
        valid_tag = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin step(1); k++; end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {31'd0, m_axis_tuser, m_axis_tdata}, 64'h1_DEAD_BEEF);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("beat", {31'd0, m_axis_tuser, m_axis_tdata}, {31'd0, e});
            end
        end
    end

    initial begin
        #2;
        chk("rst_tvalid", 64'(m_axis_tvalid), 0);
        chk("rst_tdata", 64'(m_axis_tdata), 0);
        chk("rst_tuser", 64'(m_axis_tuser), 0);
        chk("rst_armed", 64'(armed), 0);
        chk("rst_dropped", 64'(dropped_count), 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // basic interval and latency
        send(1000, 5'd1, 1'b1);
        exp_q.push_back({1'b0, 32'd500});
        send(1500, 5'd2, 1'b1);
        chk("t1_tvalid_n1", 64'(m_axis_tvalid), 0);
        step(1);
        chk("t1_tvalid_n2", 64'(m_axis_tvalid), 1);
        chk("t1_armed", 64'(armed), 0);
        drain("t1_drain");

        // latest start wins
        send(100, 5'd1, 1'b1);
        chk("t2_armed_after_start", 64'(armed), 1);
        send(300, 5'd1, 1'b1);
        exp_q.push_back({1'b0, 32'd50});
        send(350, 5'd2, 1'b1);
        chk("t2_armed_after_stop", 64'(armed), 0);
        send(400, 5'd2, 1'b1);
        drain("t2_drain");

        // disabled start is ignored
        enable = 1'b0;
        send(10, 5'd1, 1'b1);
        chk("en0_armed", 64'(armed), 0);
        enable = 1'b1;

        // shared start/stop channel: back-to-back periods
        cfg_start_channel = 5'd3; cfg_stop_channel = 5'd3;
        send(10, 5'd3, 1'b1);
        exp_q.push_back({1'b0, 32'd15});
        send(25, 5'd3, 1'b1);
        exp_q.push_back({1'b0, 32'd20});
        send(45, 5'd3, 1'b1);
        chk("t3_armed", 64'(armed), 1);
        drain("t3_drain");
        enable = 1'b0;
        step(1);
        chk("t3_disable_armed", 64'(armed), 0);
        enable = 1'b1;
        cfg_start_channel = 5'd1; cfg_stop_channel = 5'd2;

        // saturation boundaries
        send(0, 5'd1, 1'b1);
        exp_q.push_back({1'b1, 32'hFFFF_FFFF});
        send(64'h1_0000_0005, 5'd2, 1'b1);
        send(0, 5'd1, 1'b1);
        exp_q.push_back({1'b0, 32'hFFFF_FFFF});
        send(64'h0_FFFF_FFFF, 5'd2, 1'b1);
        send(1000, 5'd1, 1'b1);
        exp_q.push_back({1'b1, 32'hFFFF_FFFF});
        send(900, 5'd2, 1'b1);
        drain("t4_drain");

        // FIFO overflow under backpressure
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(64'(i * 100), 5'd1, 1'b1);
            if (i < 16) exp_q.push_back({1'b0, 32'(i + 1)});
            send(64'(i * 100 + i + 1), 5'd2, 1'b1);
        end
        step(3);
        chk("t5_dropped", 64'(dropped_count), 4);
        chk("t5_tvalid_held", 64'(m_axis_tvalid), 1);
        chk("t5_head_tdata", 64'(m_axis_tdata), 1);
        step(2);
        chk("t5_head_stable", 64'(m_axis_tdata), 1);
        m_axis_tready = 1'b1;
        drain("t5_drain");
        step(1);
        chk("t5_tvalid_empty", 64'(m_axis_tvalid), 0);

        // reset mid-operation
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(64'(i * 10), 5'd1, 1'b1);
            send(64'(i * 10 + 7), 5'd2, 1'b1);
        end
        send(500, 5'd1, 1'b1);
        step(2);
        chk("t6_pre_tvalid", 64'(m_axis_tvalid), 1);
        chk("t6_pre_armed", 64'(armed), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", 64'(m_axis_tvalid), 0);
        chk("t6_rst_armed", 64'(armed), 0);
        chk("t6_rst_dropped", 64'(dropped_count), 0);
        chk("t6_rst_tdata", 64'(m_axis_tdata), 0);
        step(2);
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        step(1);
        send(600, 5'd2, 1'b1);
        step(3);
        chk("t6_stop_ignored_tvalid", 64'(m_axis_tvalid), 0);
        chk("t6_stop_ignored_armed", 64'(armed), 0);
        chk("final_queue_empty", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
